// File: rtl/prog_mem_responder_pkg.sv
// rtl/prog_mem_responder_pkg.sv - shared widths and FSM state type for the program store responder
package prog_mem_responder_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/prog_ram_array.sv
// rtl/prog_ram_array.sv - DEPTH x DATA_W program store, async clear, sync write, comb read
module prog_ram_array
  import prog_mem_responder_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: whole array cleared by reset, one word written per enabled edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_mem_responder.sv
// rtl/prog_mem_responder.sv - PC-side responder: MAR, 3-cycle read FSM and program-load port
module prog_mem_responder
  import prog_mem_responder_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] A_IN,
  input  logic              MAR_LOAD,
  input  logic              RD_REQ,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              BUSY,
  output logic [ADDR_W-1:0] MAR_OUT,
  input  logic              PROG_MODE,
  input  logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [DATA_W-1:0] PROG_DATA,
  input  logic              PROG_WE,
  output logic              WR_ACK
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_ack_q;
  logic              rd_accept;
  logic              wr_accept;
  logic [DATA_W-1:0] mem_rdata;

  // Reads and writes are only taken in IDLE; programming mode blocks reads
  assign rd_accept = (state_q == IDLE) && RD_REQ && !PROG_MODE;
  assign wr_accept = (state_q == IDLE) && PROG_WE && PROG_MODE;

  prog_ram_array u_ram (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .we_i    (wr_accept),
    .waddr_i (PROG_ADDR),
    .wdata_i (PROG_DATA),
    .raddr_i (raddr_q),
    .rdata_o (mem_rdata)
  );

  // Next state, read-address latch and read-data capture
  always_comb begin
    state_d   = state_q;
    raddr_d   = raddr_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      IDLE: begin
        if (rd_accept) begin
          state_d = ACCESS;
          // Same-cycle MAR load bypasses the MAR so the new address is read
          raddr_d = MAR_LOAD ? A_IN : mar_q;
        end
      end
      ACCESS: begin
        state_d   = DONE;
        rd_data_d = mem_rdata;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, address and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      mar_q     <= '0;
      raddr_q   <= '0;
      rd_data_q <= '0;
      wr_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      raddr_q   <= raddr_d;
      rd_data_q <= rd_data_d;
      wr_ack_q  <= wr_accept;
      if (MAR_LOAD) begin
        mar_q <= A_IN;
      end
    end
  end

  assign RD_DATA  = rd_data_q;
  assign RD_VALID = (state_q == DONE);
  assign BUSY     = (state_q != IDLE);
  assign MAR_OUT  = mar_q;
  assign WR_ACK   = wr_ack_q;

endmodule

// File: tb/tb_prog_mem_responder.sv
// tb/tb_prog_mem_responder.sv - self-checking bench for prog_mem_responder
module tb_prog_mem_responder;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] A_IN;
  logic       MAR_LOAD;
  logic       RD_REQ;
  logic [7:0] RD_DATA;
  logic       RD_VALID;
  logic       BUSY;
  logic [3:0] MAR_OUT;
  logic       PROG_MODE;
  logic [3:0] PROG_ADDR;
  logic [7:0] PROG_DATA;
  logic       PROG_WE;
  logic       WR_ACK;

  int checks = 0;
  int errors = 0;

  prog_mem_responder dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .A_IN      (A_IN),
    .MAR_LOAD  (MAR_LOAD),
    .RD_REQ    (RD_REQ),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .BUSY      (BUSY),
    .MAR_OUT   (MAR_OUT),
    .PROG_MODE (PROG_MODE),
    .PROG_ADDR (PROG_ADDR),
    .PROG_DATA (PROG_DATA),
    .PROG_WE   (PROG_WE),
    .WR_ACK    (WR_ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit       is_write;
    bit [3:0] addr;
    bit [7:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    A_IN = 0; MAR_LOAD = 0; RD_REQ = 0;
    PROG_MODE = 0; PROG_ADDR = 0; PROG_DATA = 0; PROG_WE = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [7:0] data);
    PROG_MODE = 1; PROG_ADDR = addr; PROG_DATA = data; PROG_WE = 1;
    tick();
    PROG_WE = 0;
    check("wr_ack_pulse", WR_ACK, 1);
    tick();
    check("wr_ack_once", WR_ACK, 0);
  endtask

  task automatic do_read(input logic [3:0] addr, output logic [7:0] data);
    PROG_MODE = 0; A_IN = addr; MAR_LOAD = 1; RD_REQ = 1;
    tick();
    MAR_LOAD = 0; RD_REQ = 0;
    check("rd_busy_access", BUSY, 1);
    check("rd_valid_early", RD_VALID, 0);
    tick();
    check("rd_valid_done", RD_VALID, 1);
    data = RD_DATA;
    tick();
    check("rd_valid_drop", RD_VALID, 0);
    check("rd_busy_drop", BUSY, 0);
  endtask

  // Reference model state for the randomized phase
  logic [7:0] m_mem [16];
  logic [3:0] m_mar;
  logic [7:0] m_pend;
  logic [7:0] m_rd;
  int         m_busy_left;

  initial begin
    logic [7:0] d;
    int vcount;

    idle_inputs();
    do_reset();

    // Reset state
    check("rst_rd_data", RD_DATA, 0);
    check("rst_rd_valid", RD_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_mar", MAR_OUT, 0);
    check("rst_wr_ack", WR_ACK, 0);
    do_read(4'd0, d);
    check("rst_read0", d, 8'h00);

    // Program two words, read back with MAR bypass
    do_write(4'd3, 8'hA5);
    do_write(4'd15, 8'h3C);
    do_read(4'd3, d);
    check("read3", d, 8'hA5);
    check("mar_after_read3", MAR_OUT, 3);
    do_read(4'd15, d);
    check("read15", d, 8'h3C);

    // RD_REQ held 9 cycles: one read per 3 cycles
    PROG_MODE = 0; RD_REQ = 1;
    vcount = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("b2b_busy", BUSY, (i % 3) != 2);
      if (RD_VALID) begin
        vcount++;
        check("b2b_data", RD_DATA, 8'h3C);
      end
    end
    RD_REQ = 0;
    check("b2b_pulses", vcount, 3);

    // MAR load during ACCESS does not disturb the in-flight read
    RD_REQ = 1;
    tick();
    RD_REQ = 0;
    A_IN = 4'd7; MAR_LOAD = 1;
    tick();
    MAR_LOAD = 0;
    check("mar_access_valid", RD_VALID, 1);
    check("mar_access_data", RD_DATA, 8'h3C);
    check("mar_access_mar", MAR_OUT, 7);
    tick();

    // PROG_MODE raised mid-read: read completes, write dropped
    A_IN = 4'd15; MAR_LOAD = 1; RD_REQ = 1;
    tick();
    MAR_LOAD = 0; RD_REQ = 0;
    PROG_MODE = 1; PROG_WE = 1; PROG_ADDR = 4'd3; PROG_DATA = 8'h11;
    tick();
    PROG_WE = 0;
    check("pm_busy_valid", RD_VALID, 1);
    check("pm_busy_data", RD_DATA, 8'h3C);
    check("pm_busy_noack", WR_ACK, 0);
    tick();
    check("pm_busy_noack2", WR_ACK, 0);
    do_read(4'd3, d);
    check("pm_dropped_write", d, 8'hA5);
    do_write(4'd3, 8'h11);
    do_read(4'd3, d);
    check("pm_retry_write", d, 8'h11);

    // Table of writes and readbacks, later writes overwrite earlier ones
    vecs.push_back('{1'b1, 4'd0,  8'h01});
    vecs.push_back('{1'b1, 4'd5,  8'h5A});
    vecs.push_back('{1'b1, 4'd9,  8'hC3});
    vecs.push_back('{1'b1, 4'd5,  8'h77});
    vecs.push_back('{1'b1, 4'd8,  8'h80});
    vecs.push_back('{1'b0, 4'd0,  8'h01});
    vecs.push_back('{1'b0, 4'd5,  8'h77});
    vecs.push_back('{1'b0, 4'd9,  8'hC3});
    vecs.push_back('{1'b0, 4'd8,  8'h80});
    vecs.push_back('{1'b0, 4'd15, 8'h3C});
    vecs.push_back('{1'b0, 4'd3,  8'h11});
    vecs.push_back('{1'b0, 4'd7,  8'h00});
    foreach (vecs[i]) begin
      if (vecs[i].is_write) begin
        do_write(vecs[i].addr, vecs[i].data);
      end else begin
        do_read(vecs[i].addr, d);
        check($sformatf("table_read_a%0d", vecs[i].addr), d, vecs[i].data);
      end
    end

    // Reset asserted mid-ACCESS
    PROG_MODE = 0; A_IN = 4'd3; MAR_LOAD = 1; RD_REQ = 1;
    tick();
    MAR_LOAD = 0; RD_REQ = 0;
    check("pre_rst_busy", BUSY, 1);
    #2;
    RESET = 1;
    #1;
    check("async_rst_busy", BUSY, 0);
    check("async_rst_data", RD_DATA, 0);
    check("async_rst_mar", MAR_OUT, 0);
    check("async_rst_valid", RD_VALID, 0);
    tick();
    RESET = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_valid", RD_VALID, 0);
    end
    do_read(4'd3, d);
    check("post_rst_read3", d, 8'h00);

    // Randomized run against a transaction-level model
    idle_inputs();
    do_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_mar = 0; m_rd = 0; m_pend = 0; m_busy_left = 0;
    for (int c = 0; c < 400; c++) begin
      logic idle;
      logic exp_ack;
      int   nb;
      PROG_MODE = ($urandom_range(0, 3) == 0);
      PROG_WE   = $urandom_range(0, 1);
      PROG_ADDR = $urandom_range(0, 15);
      PROG_DATA = $urandom_range(0, 255);
      RD_REQ    = $urandom_range(0, 1);
      MAR_LOAD  = ($urandom_range(0, 2) == 0);
      A_IN      = $urandom_range(0, 15);

      idle = (m_busy_left == 0);
      if (idle && RD_REQ && !PROG_MODE) begin
        m_pend = m_mem[MAR_LOAD ? A_IN : m_mar];
        nb = 2;
      end else begin
        nb = (m_busy_left > 0) ? m_busy_left - 1 : 0;
      end
      exp_ack = idle && PROG_MODE && PROG_WE;
      if (exp_ack) m_mem[PROG_ADDR] = PROG_DATA;
      if (MAR_LOAD) m_mar = A_IN;
      if (nb == 1) m_rd = m_pend;
      m_busy_left = nb;

      tick();
      check("rnd_busy", BUSY, m_busy_left > 0);
      check("rnd_valid", RD_VALID, m_busy_left == 1);
      check("rnd_data", RD_DATA, m_rd);
      check("rnd_mar", MAR_OUT, m_mar);
      check("rnd_ack", WR_ACK, exp_ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
